// File: rtl/fir_interp_folded.sv
// fir_interp_folded: folded polyphase interpolating FIR filter.
//
// One accepted input sample produces L output samples, one per polyphase
// branch p = 0..L-1. Each output is the sum over k = 0..K-1 (K = TAPS/L) of
// x[k] * h[k*L+p]. A single multiplier is shared, so each output takes K MAC
// cycles. Input samples are two's complement and coefficients are unsigned.
// The accumulator wraps modulo 2^OUT_W.
//
// Ports:
//   ap_clk, ap_rst_n        clock (rising edge), async active-low reset
//   s_tdata/s_tvalid/s_tready  input sample stream; ready only when idle
//   m_tdata/m_tvalid/m_tready  output sample stream; held until accepted
//   coef_we/coef_addr/coef_wdata  coefficient write port, honoured only in idle
//
// Build option:
//   FIR_INTERP_SAT_EN  when defined, each output is (acc >>> (COEF_W-1)),
//                      saturated to the signed DATA_W range and sign-extended
//                      to OUT_W. When undefined, the raw accumulator is output.
module fir_interp_folded #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 12,
    parameter int unsigned TAPS   = 16,
    parameter int unsigned L      = 2,
    parameter int unsigned OUT_W  = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [DATA_W-1:0]        s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [OUT_W-1:0]         m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata
);

    localparam int unsigned K      = TAPS / L;
    localparam int unsigned AW     = $clog2(TAPS);
    localparam int unsigned KW     = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned PW     = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned PROD_W = DATA_W + COEF_W;

`ifdef FIR_INTERP_SAT_EN
    localparam logic signed [OUT_W-1:0] SAT_MAX =
        {{(OUT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN =
        {{(OUT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      x_q [K];
    logic [DATA_W-1:0]      x_d [K];
    logic [COEF_W-1:0]      h_q [TAPS];
    logic [COEF_W-1:0]      h_d [TAPS];
    logic [PW-1:0]          p_q, p_d;
    logic [KW-1:0]          k_q, k_d;
    logic [OUT_W-1:0]       acc_q, acc_d;
    logic [OUT_W-1:0]       m_tdata_q, m_tdata_d;
    logic                   m_tvalid_q, m_tvalid_d;

    // Datapath: one signed product per cycle and the running sum.
    logic [AW-1:0]          coef_idx_c;
    logic [DATA_W-1:0]      x_sel_c;
    logic [COEF_W-1:0]      h_sel_c;
    logic signed [PROD_W-1:0] x_ext_c;
    logic signed [PROD_W-1:0] h_ext_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [OUT_W-1:0]  prod_ext_c;
    logic signed [OUT_W-1:0]  sum_c;
    logic [OUT_W-1:0]         out_val_c;
`ifdef FIR_INTERP_SAT_EN
    logic signed [OUT_W-1:0]  shifted_c;
`endif

    assign s_tready = (state_q == ST_IDLE);
    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;

    // Operand select and multiply-accumulate.
    always_comb begin
        coef_idx_c = AW'(int'(k_q) * int'(L) + int'(p_q));
        x_sel_c    = x_q[k_q];
        h_sel_c    = h_q[coef_idx_c];
        // Coefficient is unsigned: zero-extend so it multiplies as a positive value.
        x_ext_c    = {{COEF_W{x_sel_c[DATA_W-1]}}, x_sel_c};
        h_ext_c    = {{DATA_W{1'b0}}, h_sel_c};
        // Magnitude always fits in PROD_W bits, so the truncation is exact.
        prod_c     = x_ext_c * h_ext_c;
        prod_ext_c = OUT_W'(prod_c);
        sum_c      = $signed(acc_q) + prod_ext_c;
    end

    // Output formatting of the final sum.
`ifdef FIR_INTERP_SAT_EN
    always_comb begin
        shifted_c = sum_c >>> (COEF_W - 1);
        if (shifted_c > SAT_MAX) begin
            out_val_c = SAT_MAX;
        end else if (shifted_c < SAT_MIN) begin
            out_val_c = SAT_MIN;
        end else begin
            out_val_c = shifted_c;
        end
    end
`else
    always_comb begin
        out_val_c = sum_c;
    end
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        h_d        = h_q;
        p_d        = p_q;
        k_d        = k_q;
        acc_d      = acc_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;

        // Coefficient writes land on the acceptance edge, before the first MAC read.
        if (coef_we && (state_q == ST_IDLE)) begin
            h_d[coef_addr] = coef_wdata;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (s_tvalid) begin
                    x_d[0] = s_tdata;
                    for (int i = 1; i < int'(K); i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    p_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = sum_c;
                if (k_q == KW'(K - 1)) begin
                    m_tdata_d  = out_val_c;
                    m_tvalid_d = 1'b1;
                    state_d    = ST_OUT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_OUT: begin
                if (m_tready) begin
                    m_tvalid_d = 1'b0;
                    if (p_q < PW'(L - 1)) begin
                        p_d     = p_q + PW'(1);
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = ST_MAC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ST_IDLE;
            x_q        <= '{default: '0};
            h_q        <= '{default: '0};
            p_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            h_q        <= h_d;
            p_q        <= p_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

endmodule
